// File: rtl/fsm_sar_scan_if.sv
// Bus between the SAR scan controller and its analog front end and result consumer.
// The slave modport is the controller side; the master modport is the front end and consumer side.
interface fsm_sar_scan_if #(
    parameter int unsigned Width = 8,
    parameter int unsigned NumCh = 4
);
    localparam int unsigned ChW = (NumCh > 1) ? $clog2(NumCh) : 1;

    logic             start_i;
    logic             cont_i;
    logic [NumCh-1:0] ch_mask_i;
    logic             cmp_i;
    logic             ready_i;
    logic [Width-1:0] dac_o;
    logic             sample_o;
    logic [ChW-1:0]   ch_sel_o;
    logic             busy_o;
    logic [Width-1:0] result_o;
    logic [ChW-1:0]   result_ch_o;
    logic             valid_o;
    logic             eoc_o;
    logic             ovr_o;

    modport slave (
        input  start_i, cont_i, ch_mask_i, cmp_i, ready_i,
        output dac_o, sample_o, ch_sel_o, busy_o, result_o, result_ch_o,
               valid_o, eoc_o, ovr_o
    );

    modport master (
        output start_i, cont_i, ch_mask_i, cmp_i, ready_i,
        input  dac_o, sample_o, ch_sel_o, busy_o, result_o, result_ch_o,
               valid_o, eoc_o, ovr_o
    );
endinterface

// File: rtl/fsm_sar_scan.sv
// Multi-channel SAR binary-search controller with sample/settle timing,
// a valid/ready result holding register and single or continuous scan.
module fsm_sar_scan #(
    parameter int unsigned Width        = 8,
    parameter int unsigned NumCh        = 4,
    parameter int unsigned SampleCycles = 2,
    parameter int unsigned SettleCycles = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fsm_sar_scan_if.slave     bus
);
    localparam int unsigned ChW    = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned BitW   = $clog2(Width);
    localparam int unsigned CntMax = (SampleCycles > SettleCycles + 1) ? SampleCycles
                                                                       : SettleCycles + 1;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [Width-1:0] sar_q, sar_d;
    logic [NumCh-1:0] mask_q, mask_d;
    logic [ChW-1:0]   ch_q, ch_d;
    logic [ChW:0]     hit;

    logic [Width-1:0] dac_q, dac_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic [Width-1:0] result_q, result_d;
    logic [ChW-1:0]   result_ch_q, result_ch_d;
    logic             valid_q, valid_d;
    logic             eoc_q, eoc_d;
    logic             ovr_q, ovr_d;

    // First set mask bit at index >= from; MSB of the return flags a hit.
    function automatic logic [ChW:0] find_set(input logic [NumCh-1:0] m,
                                              input int unsigned from);
        logic [ChW:0] r;
        r = '0;
        for (int unsigned i = 0; i < NumCh; i++) begin
            if (!r[ChW] && i >= from && m[i]) r = {1'b1, ChW'(i)};
        end
        return r;
    endfunction

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sar_q       <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            dac_q       <= '0;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            eoc_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sar_q       <= sar_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            dac_q       <= dac_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            valid_q     <= valid_d;
            eoc_q       <= eoc_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state, timing counters, SAR register and channel walk
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sar_d   = sar_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        hit     = '0;
        unique case (state_q)
            IDLE: begin
                hit = find_set(bus.ch_mask_i, 0);
                if (bus.start_i && hit[ChW]) begin
                    state_d = SAMPLE;
                    mask_d  = bus.ch_mask_i;
                    ch_d    = hit[ChW-1:0];
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == CntW'(SampleCycles - 1)) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    bit_d   = BitW'(Width - 1);
                    sar_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            CONV: begin
                // Comparator decision is taken on the last settle clock of each bit.
                if (cnt_q == CntW'(SettleCycles)) begin
                    cnt_d = '0;
                    if (bus.cmp_i) sar_d = sar_q | (Width'(1) << bit_q);
                    if (bit_q == '0) state_d = DONE;
                    else             bit_d   = bit_q - BitW'(1);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
                hit   = find_set(mask_q, 32'(ch_q) + 32'd1);
                if (hit[ChW]) begin
                    state_d = SAMPLE;
                    ch_d    = hit[ChW-1:0];
                end else if (bus.cont_i) begin
                    mask_d = bus.ch_mask_i;
                    hit    = find_set(bus.ch_mask_i, 0);
                    if (hit[ChW]) begin
                        state_d = SAMPLE;
                        ch_d    = hit[ChW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs decoded from the upcoming state
    always_comb begin
        dac_d       = '0;
        sample_d    = 1'b0;
        busy_d      = (state_d != IDLE);
        eoc_d       = 1'b0;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        valid_d     = valid_q & ~bus.ready_i;
        ovr_d       = ovr_q;
        if (state_q == IDLE && state_d == SAMPLE) ovr_d = 1'b0;
        unique case (state_d)
            SAMPLE: sample_d = 1'b1;
            CONV:   dac_d    = sar_d | (Width'(1) << bit_d);
            DONE: begin
                dac_d       = sar_d;
                eoc_d       = 1'b1;
                result_d    = sar_d;
                result_ch_d = ch_q;
                valid_d     = 1'b1;
                if (valid_q && !bus.ready_i) ovr_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.dac_o       = dac_q;
    assign bus.sample_o    = sample_q;
    assign bus.ch_sel_o    = ch_q;
    assign bus.busy_o      = busy_q;
    assign bus.result_o    = result_q;
    assign bus.result_ch_o = result_ch_q;
    assign bus.valid_o     = valid_q;
    assign bus.eoc_o       = eoc_q;
    assign bus.ovr_o       = ovr_q;

endmodule

// File: tb/tb_fsm_sar_scan.sv
// Self-checking bench for fsm_sar_scan: ideal comparator front end, per-channel
// input voltages, and an arithmetic model of the expected DAC trace and results.
module tb_fsm_sar_scan;
    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int T   = 1;
    localparam int N   = S + W * (T + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_eoc = 0;
    logic [W-1:0] vin [NCH];

    fsm_sar_scan_if #(.Width(W), .NumCh(NCH)) bus ();

    fsm_sar_scan #(
        .Width(W), .NumCh(NCH), .SampleCycles(S), .SettleCycles(T)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.cmp_i = (vin[bus.ch_sel_o] >= bus.dac_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows one conversion on channel ch from its first SAMPLE cycle through DONE.
    task automatic expect_conv(input int ch, input bit chained);
        int n, k, vi, e;
        n = 0;
        while (bus.sample_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("conv_start", 32'(bus.sample_o), 32'd1);
        if (bus.sample_o !== 1'b1) return;
        vi = int'(vin[ch]);
        for (int t = 0; t <= N; t++) begin
            if (t > 0) @(negedge clk);
            if (t < S) begin
                e = 0;
            end else if (t < N) begin
                k = W - 1 - (t - S) / (T + 1);
                e = ((vi >> (k + 1)) << (k + 1)) | (1 << k);
            end else begin
                e = vi;
            end
            check("dac", 32'(bus.dac_o), 32'(e));
            check("sample", 32'(bus.sample_o), (t < S) ? 32'd1 : 32'd0);
            check("ch_sel", 32'(bus.ch_sel_o), 32'(ch));
            check("busy", 32'(bus.busy_o), 32'd1);
            check("eoc", 32'(bus.eoc_o), (t == N) ? 32'd1 : 32'd0);
        end
        check("result", 32'(bus.result_o), 32'(vi));
        check("result_ch", 32'(bus.result_ch_o), 32'(ch));
        check("valid", 32'(bus.valid_o), 32'd1);
        if (chained) check("eoc_spacing", 32'(cyc - last_eoc), 32'(N + 1));
        last_eoc = cyc;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] mask);
        bus.ch_mask_i = mask;
        bus.start_i   = 1'b1;
        @(negedge clk);
        bus.start_i   = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_sample"}, 32'(bus.sample_o), 32'd0);
        check({tag, "_dac"}, 32'(bus.dac_o), 32'd0);
    endtask

    initial begin
        int eocs;
        bit first;
        logic [NCH-1:0] m;
        bus.start_i   = 1'b0;
        bus.cont_i    = 1'b0;
        bus.ch_mask_i = '0;
        bus.ready_i   = 1'b1;
        for (int i = 0; i < NCH; i++) vin[i] = W'($urandom);

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("rst");
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_eoc", 32'(bus.eoc_o), 32'd0);
        check("rst_ovr", 32'(bus.ovr_o), 32'd0);
        check("rst_result", 32'(bus.result_o), 32'd0);
        check("rst_ch_sel", 32'(bus.ch_sel_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversion on ch0 with Vin = 0xA5
        vin[0] = 8'hA5;
        pulse_start(4'b0001);
        expect_conv(0, 1'b0);
        @(negedge clk);
        check_idle("single_end");
        check("single_valid_drop", 32'(bus.valid_o), 32'd0);
        check("single_ch_hold", 32'(bus.ch_sel_o), 32'd0);

        // Masked scan, mask changes after start must not matter
        vin[1] = 8'h00;
        vin[3] = 8'hFF;
        pulse_start(4'b1010);
        bus.ch_mask_i = 4'b0101;
        expect_conv(1, 1'b0);
        expect_conv(3, 1'b1);
        @(negedge clk);
        check_idle("masked_end");
        check("masked_ch_hold", 32'(bus.ch_sel_o), 32'd3);

        // Continuous mode: three sweeps over channels 0 and 2
        vin[0] = W'($urandom);
        vin[2] = W'($urandom);
        bus.cont_i = 1'b1;
        pulse_start(4'b0101);
        expect_conv(0, 1'b0);
        expect_conv(2, 1'b1);
        expect_conv(0, 1'b1);
        expect_conv(2, 1'b1);
        expect_conv(0, 1'b1);
        bus.cont_i = 1'b0;
        expect_conv(2, 1'b1);
        @(negedge clk);
        check_idle("cont_end");

        // Overrun: consumer stalls across two results
        bus.ready_i = 1'b0;
        vin[0] = W'($urandom);
        vin[1] = W'($urandom);
        pulse_start(4'b0011);
        expect_conv(0, 1'b0);
        check("ovr_first", 32'(bus.ovr_o), 32'd0);
        expect_conv(1, 1'b1);
        check("ovr_second", 32'(bus.ovr_o), 32'd1);
        repeat (3) @(negedge clk);
        check("ovr_hold_valid", 32'(bus.valid_o), 32'd1);
        check("ovr_hold_result", 32'(bus.result_o), 32'(vin[1]));
        check("ovr_hold_flag", 32'(bus.ovr_o), 32'd1);
        bus.ready_i = 1'b1;
        @(negedge clk);
        check("ovr_accept_valid", 32'(bus.valid_o), 32'd0);
        check("ovr_sticky", 32'(bus.ovr_o), 32'd1);
        pulse_start(4'b0001);
        check("ovr_cleared", 32'(bus.ovr_o), 32'd0);
        expect_conv(0, 1'b0);

        // Guard: start with an empty mask
        @(negedge clk);
        bus.ch_mask_i = '0;
        bus.start_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("zero_mask");
        end
        bus.start_i = 1'b0;

        // Guard: start during CONV does not add a conversion
        vin[0] = W'($urandom);
        pulse_start(4'b0001);
        repeat (6) @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        eocs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.eoc_o === 1'b1) begin
                eocs++;
                check("guard_result", 32'(bus.result_o), 32'(vin[0]));
            end
        end
        check("guard_eoc_count", 32'(eocs), 32'd1);
        check_idle("guard_end");

        // Asynchronous reset while converting bit 4 of ch2
        vin[2] = W'($urandom);
        pulse_start(4'b0100);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_valid", 32'(bus.valid_o), 32'd0);
        check("async_rst_eoc", 32'(bus.eoc_o), 32'd0);
        check("async_rst_ch_sel", 32'(bus.ch_sel_o), 32'd0);
        check("async_rst_result", 32'(bus.result_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vin[1] = W'($urandom);
        pulse_start(4'b0010);
        expect_conv(1, 1'b0);

        // Random single sweeps with random masks and voltages
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) vin[i] = W'($urandom);
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            pulse_start(m);
            bus.ch_mask_i = NCH'($urandom);
            first = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    expect_conv(c, !first);
                    first = 1'b0;
                end
            end
            @(negedge clk);
            check_idle("rand_end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
